// File: rtl/glyph_pixel_pipe.sv
// Glyph pixel output stage: glyph ROM addressing, playfield background, aligned RGB/syncs.
// Optional macro GLYPH_TRANSPARENCY_EN: KEY_COLOR glyph pixels show the background.
module glyph_pixel_pipe #(
  parameter int          GLYPH_ADDR_WIDTH = 16,
  parameter int          ROM_LATENCY      = 1,
  parameter int          X_START          = 158,
  parameter int          TRACK_Y0         = 400,
  parameter int          TRACK_Y1         = 432,
  parameter logic [23:0] KEY_COLOR        = 24'h000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bright,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic [9:0]                  hcount,
  input  logic [9:0]                  vcount,
  input  logic                        pix_en,
  input  logic [GLYPH_ADDR_WIDTH-1:0] glyph_addr,
  input  logic [23:0]                 bg_color,
  input  logic [23:0]                 grid_color,
  input  logic [23:0]                 track_color,
  input  logic [23:0]                 bound_color,
  output logic [GLYPH_ADDR_WIDTH-1:0] glyph_rom_addr,
  input  logic [23:0]                 glyph_rom_data,
  output logic [23:0]                 rgb,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        bright_out,
  output logic [15:0]                 frame_count
);

  localparam int D = ROM_LATENCY + 1;

  localparam logic [1:0] CL_BG    = 2'd0;
  localparam logic [1:0] CL_GRID  = 2'd1;
  localparam logic [1:0] CL_TRACK = 2'd2;
  localparam logic [1:0] CL_BOUND = 2'd3;

  localparam logic [9:0] XS  = 10'(X_START);
  localparam logic [9:0] TY0 = 10'(TRACK_Y0);
  localparam logic [9:0] TY1 = 10'(TRACK_Y1);

`ifdef GLYPH_TRANSPARENCY_EN
  localparam logic TRANSP = 1'b1;
`else
  localparam logic TRANSP = 1'b0;
`endif

  // stage word: {class[1:0], pix_en, bright, hsync, vsync}
  localparam logic [5:0] STG_RST = {CL_BG, 1'b0, 1'b0, 1'b1, 1'b1};

  logic [9:0]  w_x;
  logic [1:0]  w_cls;
  logic [5:0]  w_tail;
  logic [23:0] w_bgc;
  logic        w_glyph;
  logic [23:0] w_pix;

  logic [GLYPH_ADDR_WIDTH-1:0] r_addr;
  logic [5:0]                  r_dly [0:D];
  logic [23:0]                 r_rom_q;
  logic [23:0]                 r_rgb;
  logic                        r_hs;
  logic                        r_vs;
  logic                        r_br;
  logic                        r_vs_prev;
  logic [15:0]                 r_frame_cnt;

  assign w_x = hcount - XS;

  always_comb begin
    w_cls = CL_BG;
    if (w_x == 10'd0 || w_x == 10'd639 ||
        vcount == 10'd0 || vcount == 10'd479)
      w_cls = CL_BOUND;
    else if (vcount >= TY0 && vcount < TY1)
      w_cls = CL_TRACK;
    else if (w_x[4:0] == 5'd0 || vcount[4:0] == 5'd0)
      w_cls = CL_GRID;
  end

  // stage 0 is S0; stage D lines up with the captured ROM word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      for (int i = 0; i <= D; i++) r_dly[i] <= STG_RST;
      r_rom_q <= '0;
    end else begin
      if (pix_en) r_addr <= glyph_addr;
      r_dly[0] <= {w_cls, pix_en, bright, hsync, vsync};
      for (int i = 1; i <= D; i++) r_dly[i] <= r_dly[i-1];
      r_rom_q <= glyph_rom_data;
    end
  end

  assign w_tail = r_dly[D];

  always_comb begin
    w_bgc = bg_color;
    unique case (w_tail[5:4])
      CL_BOUND: w_bgc = bound_color;
      CL_TRACK: w_bgc = track_color;
      CL_GRID:  w_bgc = grid_color;
      default:  w_bgc = bg_color;
    endcase
  end

  always_comb begin
    w_glyph = w_tail[3] && !(TRANSP && r_rom_q == KEY_COLOR);
    w_pix   = w_glyph ? r_rom_q : w_bgc;
    if (!w_tail[2]) w_pix = 24'h000000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb <= '0;
      r_br  <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= w_pix;
      r_br  <= w_tail[2];
      r_hs  <= w_tail[1];
      r_vs  <= w_tail[0];
    end
  end

  // a frame ends when the active-low vsync pulse releases
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_prev   <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      r_vs_prev <= vsync;
      if (!r_vs_prev && vsync) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign glyph_rom_addr = r_addr;
  assign rgb            = r_rgb;
  assign hsync_out      = r_hs;
  assign vsync_out      = r_vs;
  assign bright_out     = r_br;
  assign frame_count    = r_frame_cnt;

endmodule

// File: tb/tb_glyph_pixel_pipe.sv
// Randomized + directed bench for glyph_pixel_pipe against a pixel-level reference.
// Honors GLYPH_TRANSPARENCY_EN the same way as the design.
module tb_glyph_pixel_pipe;

  localparam logic [23:0] KEY  = 24'h000000;
  localparam int          X0   = 158;
  localparam logic [23:0] C_BG = 24'h102030;
  localparam logic [23:0] C_GR = 24'h405060;
  localparam logic [23:0] C_TR = 24'h708090;
  localparam logic [23:0] C_BD = 24'hA0B0C0;

`ifdef GLYPH_TRANSPARENCY_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        bright, hsync, vsync, pix_en;
  logic [9:0]  hcount, vcount;
  logic [15:0] glyph_addr;
  logic [15:0] glyph_rom_addr;
  logic [23:0] rom_q = '0;
  logic [23:0] rgb;
  logic        hsync_out, vsync_out, bright_out;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  glyph_pixel_pipe dut (
    .clk(clk), .reset(reset),
    .bright(bright), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount),
    .pix_en(pix_en), .glyph_addr(glyph_addr),
    .bg_color(C_BG), .grid_color(C_GR),
    .track_color(C_TR), .bound_color(C_BD),
    .glyph_rom_addr(glyph_rom_addr),
    .glyph_rom_data(rom_q),
    .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .bright_out(bright_out),
    .frame_count(frame_count)
  );

  function automatic logic [23:0] rom_fn(logic [15:0] a);
    if (a == 16'h0042) return 24'hABCDEF;
    if (a[3:0] == 4'h0) return 24'h000000;
    return {a[7:0] ^ 8'h5A, a[15:8] + 8'h01, a[7:0] + 8'h11};
  endfunction

  // one-cycle synchronous glyph ROM
  always @(posedge clk) rom_q <= rom_fn(glyph_rom_addr);

  function automatic logic [23:0] bg_col(int hc, int vc);
    int x;
    x = (((hc - X0) % 1024) + 1024) % 1024;
    if (x == 0 || x == 639 || vc == 0 || vc == 479) return C_BD;
    if (vc >= 400 && vc < 432) return C_TR;
    if (x % 32 == 0 || vc % 32 == 0) return C_GR;
    return C_BG;
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  logic [23:0] q_rgb [$];
  logic        q_hs  [$];
  logic        q_vs  [$];
  logic        q_br  [$];
  logic [15:0] m_addr;
  logic [15:0] m_fc;
  logic        m_vsp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc_no, obs, exp);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic b, input logic hs, input logic vs,
                      input int hc, input int vc,
                      input logic pe, input logic [15:0] ga);
    logic [23:0] e;
    logic [23:0] g;
    bright = b; hsync = hs; vsync = vs;
    hcount = 10'(hc); vcount = 10'(vc);
    pix_en = pe; glyph_addr = ga;
    @(posedge clk);
    cyc_no++;
    if (reset) begin
      if (pe) m_addr = ga;
      if (!m_vsp && vs) m_fc = m_fc + 16'd1;
      m_vsp = vs;
      g = rom_fn(ga);
      if (!b) e = 24'h0;
      else if (pe && !(TR && g == KEY)) e = g;
      else e = bg_col(hc, vc);
      q_rgb.push_back(e);
      q_hs.push_back(hs);
      q_vs.push_back(vs);
      q_br.push_back(b);
    end
    @(negedge clk);
    if (q_rgb.size() == 4) begin
      chk("rgb", 32'(rgb), 32'(q_rgb.pop_front()));
      chk("hsync_out", 32'(hsync_out), 32'(q_hs.pop_front()));
      chk("vsync_out", 32'(vsync_out), 32'(q_vs.pop_front()));
      chk("bright_out", 32'(bright_out), 32'(q_br.pop_front()));
    end else begin
      chk("rgb_rst", 32'(rgb), 32'h0);
      chk("hsync_rst", 32'(hsync_out), 32'h1);
      chk("vsync_rst", 32'(vsync_out), 32'h1);
      chk("bright_rst", 32'(bright_out), 32'h0);
    end
    chk("rom_addr", 32'(glyph_rom_addr), 32'(m_addr));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic rand_step();
    int r, hc, vc;
    r = int'($urandom % 6);
    hc = (r == 0) ? 158 : (r == 1) ? 797 : (r == 2) ? 190 :
         int'($urandom_range(0, 1023));
    r = int'($urandom % 6);
    vc = (r == 0) ? 0 : (r == 1) ? 479 :
         (r == 2) ? int'($urandom_range(398, 433)) :
         (r == 3) ? 64 : int'($urandom_range(0, 1023));
    step(($urandom % 5) != 0, ($urandom % 4) != 0,
         ($urandom % 6) != 0, hc, vc, ($urandom % 2) != 0,
         16'($urandom));
  endtask

  initial begin
    reset = 1'b0;
    bright = 1'b1; hsync = 1'b0; vsync = 1'b0; pix_en = 1'b1;
    hcount = 10'd300; vcount = 10'd200; glyph_addr = 16'h1234;
    m_addr = '0; m_fc = '0; m_vsp = 1'b1;
    @(negedge clk);

    // held in reset mid-frame with live-looking inputs
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 300 + i, 200, 1'b1, 16'h1234 + 16'(i));
    reset = 1'b1;

    // latency alignment
    step(1'b1, 1'b1, 1'b1, 300, 300, 1'b1, 16'h0042);
    // background priority
    step(1'b1, 1'b1, 1'b1, 158, 200, 1'b0, 16'h0111);
    step(1'b1, 1'b1, 1'b1, 190, 410, 1'b0, 16'h0222);
    step(1'b1, 1'b1, 1'b1, 222, 100, 1'b0, 16'h0333);
    step(1'b1, 1'b1, 1'b1, 200, 100, 1'b0, 16'h0444);
    // blanking with syncs moving
    step(1'b0, 1'b0, 1'b1, 250, 100, 1'b1, 16'h0555);
    step(1'b0, 1'b1, 1'b1, 251, 100, 1'b1, 16'h0556);
    step(1'b0, 1'b0, 1'b1, 252, 100, 1'b1, 16'h0557);
    // key-colour glyph pixel
    step(1'b1, 1'b1, 1'b1, 200, 100, 1'b1, 16'h0010);
    // back-to-back pix_en toggling
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b1, 300 + i, 250, 1'(i % 2), 16'h0900 + 16'(i));
    // three frame pulses
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 400, 490, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b1, 401, 490, 1'b0, 16'h0);
    end
    chk("three_frames", 32'(frame_count), 32'd3);

    for (int i = 0; i < 300; i++) rand_step();

    // asynchronous reset in the middle of a cycle
    #2 reset = 1'b0;
    #1;
    chk("arst_rgb", 32'(rgb), 32'h0);
    chk("arst_hs", 32'(hsync_out), 32'h1);
    chk("arst_vs", 32'(vsync_out), 32'h1);
    chk("arst_br", 32'(bright_out), 32'h0);
    chk("arst_addr", 32'(glyph_rom_addr), 32'h0);
    chk("arst_fc", 32'(frame_count), 32'h0);
    q_rgb.delete(); q_hs.delete(); q_vs.delete(); q_br.delete();
    m_addr = '0; m_fc = '0; m_vsp = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 170, 20, 1'b1, 16'h0042);
    reset = 1'b1;
    for (int i = 0; i < 200; i++) rand_step();

    // counter wrap from a preloaded all-ones value
    step(1'b1, 1'b1, 1'b1, 300, 300, 1'b0, 16'h0);
    force dut.r_frame_cnt = 16'hFFFF;
    m_fc = 16'hFFFF;
    step(1'b1, 1'b1, 1'b1, 300, 300, 1'b0, 16'h0);
    release dut.r_frame_cnt;
    step(1'b1, 1'b1, 1'b0, 300, 300, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 300, 300, 1'b0, 16'h0);
    chk("fc_wrap", 32'(frame_count), 32'h0);

    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b1, 300, 300, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glyph_pixel_pipe.md
# glyph_pixel_pipe

Pixel output stage directly downstream of the glyph address generator. It registers the per-pixel glyph ROM address and the `pix_en` flag, then waits out the glyph ROM read latency. It renders the playfield background (boundary, track, grid, plain) and picks glyph or background colour. It drives a 24-bit RGB value with hsync, vsync and bright all delayed by the same number of cycles, so the VGA DAC sees a consistent pixel.

## Interface
Parameters:
- `GLYPH_ADDR_WIDTH`, 16, glyph ROM address width
- `ROM_LATENCY`, 1, glyph ROM read latency in cycles (1..4)
- `X_START`, 158, hcount value of the first visible column
- `TRACK_Y0`, 400, first row of the track band
- `TRACK_Y1`, 432, first row below the track band
- `KEY_COLOR`, 24'h000000, transparent glyph colour (used only with `GLYPH_TRANSPARENCY_EN`)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `bright`, `hsync`, `vsync`  in  1 each  raw VGA timing; syncs are active-low
- `hcount`, `vcount`  in  10 each  raw counters
- `pix_en`  in  1  glyph pixel present at this hcount/vcount
- `glyph_addr`  in  GLYPH_ADDR_WIDTH  glyph ROM address, valid when `pix_en` is high
- `bg_color`, `grid_color`, `track_color`, `bound_color`  in  24 each  palette
- `glyph_rom_addr`  out  GLYPH_ADDR_WIDTH  registered address to the glyph ROM
- `glyph_rom_data`  in  24  ROM pixel, valid ROM_LATENCY cycles after the address
- `rgb`  out  24  final pixel colour
- `hsync_out`, `vsync_out`, `bright_out`  out  1 each  delayed timing
- `frame_count`  out  16  count of completed frames

## Operation
- Stage S0 (registered on each clk):
  - `glyph_rom_addr` ← `glyph_addr` when `pix_en` is high; otherwise it holds its value.
  - Background class is computed and captured.
  - `pix_en`, `bright`, `hsync` and `vsync` enter a delay line.
- Background class is computed from x = hcount − X_START (10-bit, wraps) and y = vcount. Priority, highest first:
  - BOUND: x==0, x==639, y==0 or y==479
  - TRACK: TRACK_Y0 ≤ y < TRACK_Y1
  - GRID: x[4:0]==0 or y[4:0]==0
  - BG: everything else
- Class is 2-bit and is delayed alongside `pix_en`.
- Output stage (last register):
  - `bright` delayed and low → `rgb` = 0
  - else delayed `pix_en` high → `rgb` = `glyph_rom_data`
  - else → colour of the delayed class
- Palette inputs are sampled at the output stage, not delayed. They must be static within a frame.
- `frame_count` increments on the rising edge of `vsync` (end of the sync pulse). It wraps from 16'hFFFF to 0.
- Delay line depth D = ROM_LATENCY + 1. Implemented as a shift register of {class, pix_en, bright, hsync, vsync}.

## Timing
- Total latency from inputs to `rgb`/`*_out` is L = ROM_LATENCY + 2 cycles. At the default, L = 3.
- Input sampled at edge n → `glyph_rom_addr` valid after edge n.
  - ROM data is used at edge n+1+ROM_LATENCY.
  - Outputs are valid after edge n+L.
- Syncs, bright and rgb of the same source pixel always appear in the same cycle. There is no skew between them.
- `glyph_rom_addr` is not qualified downstream: a stale value while `pix_en` is low is harmless.
- Reset (async assert, sync release by the external reset circuit) clears all outputs and delay-line stages to:
  - `rgb` = 0, `bright_out` = 0
  - `hsync_out` = 1, `vsync_out` = 1
  - `glyph_rom_addr` = 0, `frame_count` = 0
  - delayed `pix_en` = 0, class = BG
- Reset mid-line: the first L cycles after release output the reset values, then normal pixels follow. No partial pixel escapes.
- Back-to-back `pix_en` toggles every cycle are supported. Every cycle is an independent pixel and there is no handshake stall.

## Configuration
- `GLYPH_TRANSPARENCY_EN` defined:
  - when delayed `pix_en` is high and `glyph_rom_data` == KEY_COLOR, the background class colour is output instead. Glyph corners show the playfield.
- Not defined:
  - any pixel with delayed `pix_en` high outputs `glyph_rom_data` unconditionally, including KEY_COLOR.
  - `KEY_COLOR` is unused.

## Test plan
- Reset check: hold `reset`=0 mid-frame, then release.
  - Required: `rgb`=0, `hsync_out`=`vsync_out`=1, `frame_count`=0 until L=3 cycles after the first valid input.
- Latency alignment: bright=1, pix_en=1, glyph_addr=16'h0042, ROM model returns 24'hABCDEF one cycle after address 0x42.
  - Required: `glyph_rom_addr`=0x42 after 1 edge; `rgb`=24'hABCDEF with `bright_out`=1 exactly 3 edges after the input.
- Background priority, with pix_en=0 and bright=1:
  - hcount=158, vcount=200 → bound_color
  - hcount=190, vcount=410 → track_color
  - hcount=222, vcount=100 → grid_color
  - hcount=200, vcount=100 → bg_color
- Blanking: bright=0 with pix_en=1.
  - Required: `rgb`=0 after 3 cycles, while `hsync_out` follows `hsync` delayed by 3.
- Transparency: `GLYPH_TRANSPARENCY_EN` defined, ROM returns 24'h000000 at hcount=200, vcount=100.
  - Required: `rgb`=bg_color. Same case without the macro: `rgb`=0.
- Frame counter: drive 3 vsync low→high pulses.
  - Required: `frame_count`=3. Preload to 16'hFFFF by running 65535 frames, or by a forced value in the bench; the next pulse must give 0.
